// File: rtl/data_ram_hs.sv
// Byte-addressable RV32I data memory with valid/ready request/response channels,
// optional wait states and error responses for faulting accesses.
module data_ram_hs #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq_Valid,
    output logic        oReq_Ready,
    input  logic        iReq_WrEn,
    input  logic [2:0]  iReq_Funct3,
    input  logic [31:0] iReq_Addr,
    input  logic [31:0] iReq_WrData,
    output logic        oRsp_Valid,
    input  logic        iRsp_Ready,
    output logic [31:0] oRsp_RdData,
    output logic        oRsp_Err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic [31:0]        offset;
    logic [IDX_W-1:0]   idx;
    logic               misaligned;
    logic               out_of_range;
    logic               bad_funct3;
    logic               req_err;
    logic [3:0]         lanes;
    logic [31:0]        wr_word;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_ext;

    assign oReq_Ready = (state_q == S_IDLE) && !iRst;
    assign accept     = iReq_Valid && oReq_Ready;

    // Request decode: fault detection and word index
    always_comb begin
        offset       = iReq_Addr - 32'(BASE_ADDR);
        idx          = offset[IDX_W+1:2];
        out_of_range = (iReq_Addr < 32'(BASE_ADDR)) || ((offset >> 2) >= 32'(DEPTH_WORDS));
        misaligned   = ((iReq_Funct3[1:0] == 2'b01) && iReq_Addr[0]) ||
                       ((iReq_Funct3[1:0] == 2'b10) && (iReq_Addr[1:0] != 2'b00));
        if (iReq_WrEn) begin
            bad_funct3 = iReq_Funct3[2] || (iReq_Funct3[1:0] == 2'b11);
        end else begin
            bad_funct3 = (iReq_Funct3[1:0] == 2'b11) || (iReq_Funct3 == 3'b110);
        end
        req_err = misaligned || out_of_range || bad_funct3;
    end

    // Store lane enables and replicated write data
    always_comb begin
        lanes   = 4'b1111;
        wr_word = iReq_WrData;
        case (iReq_Funct3[1:0])
            2'b00: begin
                lanes   = 4'b0001 << iReq_Addr[1:0];
                wr_word = {4{iReq_WrData[7:0]}};
            end
            2'b01: begin
                lanes   = iReq_Addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{iReq_WrData[15:0]}};
            end
            default: begin
                lanes   = 4'b1111;
                wr_word = iReq_WrData;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[8*iReq_Addr[1:0] +: 8];
        rd_half = iReq_Addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (iReq_Funct3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_ext = rd_word;
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = 32'd0;
        endcase
    end

    // Storage is deliberately not reset
    always_ff @(posedge iClk) begin
        if (accept && iReq_WrEn && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (iRsp_Ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            oRsp_Valid  <= 1'b0;
            oRsp_RdData <= 32'd0;
            oRsp_Err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oRsp_Valid <= (state_d == S_RESP);
            if (accept) begin
                oRsp_RdData <= (req_err || iReq_WrEn) ? 32'd0 : rd_ext;
                oRsp_Err    <= req_err;
            end else if ((state_q == S_RESP) && iRsp_Ready) begin
                oRsp_RdData <= 32'd0;
                oRsp_Err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_hs.sv
// Directed and random load/store traffic for data_ram_hs, checked against a byte-array model.
module tb_data_ram_hs;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned BASE  = 32'h100;
    localparam int unsigned WAITC = 3;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReq_Valid;
    logic        oReq_Ready;
    logic        iReq_WrEn;
    logic [2:0]  iReq_Funct3;
    logic [31:0] iReq_Addr;
    logic [31:0] iReq_WrData;
    logic        oRsp_Valid;
    logic        iRsp_Ready;
    logic [31:0] oRsp_RdData;
    logic        oRsp_Err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mm [4*DEPTH];

    data_ram_hs #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iReq_Valid (iReq_Valid),
        .oReq_Ready (oReq_Ready),
        .iReq_WrEn  (iReq_WrEn),
        .iReq_Funct3(iReq_Funct3),
        .iReq_Addr  (iReq_Addr),
        .iReq_WrData(iReq_WrData),
        .oRsp_Valid (oRsp_Valid),
        .iRsp_Ready (iRsp_Ready),
        .oRsp_RdData(oRsp_RdData),
        .oRsp_Err   (oRsp_Err)
    );

    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Little-endian byte memory model; applies stores and returns expected response
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] d, output logic e);
        longint off;
        int size;
        logic [63:0] v;
        e = 1'b0;
        d = 32'd0;
        if (wr && f3 > 3'd2) e = 1'b1;
        if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e = 1'b1;
        size = 1 << f3[1:0];
        if (f3[1:0] != 2'b11 && (addr % size) != 0) e = 1'b1;
        off = longint'(addr) - longint'(BASE);
        if (off < 0 || off >= longint'(4*DEPTH)) e = 1'b1;
        if (e) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mm[int'(off) + i] = wd[8*i +: 8];
        end else begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = v | (64'(mm[int'(off) + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
            d = v[31:0];
        end
    endtask

    // One full request/response; starts and ends #1 after a rising edge in IDLE
    task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic [31:0] ed;
        logic        ee;
        int          n;
        model(wr, f3, addr, wd, ed, ee);
        iReq_Valid  = 1'b1;
        iReq_WrEn   = wr;
        iReq_Funct3 = f3;
        iReq_Addr   = addr;
        iReq_WrData = wd;
        chk("req_ready_idle", 32'(oReq_Ready), 32'd1);
        @(posedge iClk); #1;
        iReq_Valid  = 1'b0;
        iReq_WrEn   = 1'($urandom);
        iReq_Funct3 = 3'($urandom);
        iReq_Addr   = $urandom;
        iReq_WrData = $urandom;
        n = 0;
        while (!oRsp_Valid && n < 40) begin
            chk("req_ready_busy", 32'(oReq_Ready), 32'd0);
            @(posedge iClk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(WAITC));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(oRsp_Valid), 32'd1);
            chk("hold_ready", 32'(oReq_Ready), 32'd0);
            chk("hold_data", oRsp_RdData, ed);
            chk("hold_err", 32'(oRsp_Err), 32'(ee));
            @(posedge iClk); #1;
        end
        iRsp_Ready = 1'b1;
        chk("rsp_valid", 32'(oRsp_Valid), 32'd1);
        chk("rsp_data", oRsp_RdData, ed);
        chk("rsp_err", 32'(oRsp_Err), 32'(ee));
        got = oRsp_RdData;
        @(posedge iClk); #1;
        iRsp_Ready = 1'b0;
        chk("rsp_valid_drop", 32'(oRsp_Valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] ed;
        logic        ee;
        logic [31:0] a;
        logic [2:0]  f;
        int          sel;

        iRst = 1'b1; iReq_Valid = 1'b0; iReq_WrEn = 1'b0; iReq_Funct3 = 3'd0;
        iReq_Addr = 32'd0; iReq_WrData = 32'd0; iRsp_Ready = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        chk("reset_valid", 32'(oRsp_Valid), 32'd0);
        chk("reset_data", oRsp_RdData, 32'd0);
        chk("reset_err", 32'(oRsp_Err), 32'd0);
        chk("reset_ready", 32'(oReq_Ready), 32'd0);
        iRst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(oReq_Ready), 32'd1);
        @(posedge iClk); #1;

        for (int w = 0; w < int'(DEPTH); w++) txn(1'b1, 3'b010, BASE + 32'(4*w), $urandom, 0, got);

        // Byte merge and sign/zero extension
        txn(1'b1, 3'b010, BASE + 32'h4, 32'h11223344, 0, got);
        txn(1'b1, 3'b000, BASE + 32'h5, 32'h000000AB, 0, got);
        txn(1'b0, 3'b010, BASE + 32'h4, 32'd0, 1, got);
        chk("t1_lw", got, 32'h1122AB44);
        txn(1'b0, 3'b000, BASE + 32'h5, 32'd0, 0, got);
        chk("t1_lb", got, 32'hFFFFFFAB);
        txn(1'b0, 3'b100, BASE + 32'h5, 32'd0, 0, got);
        chk("t1_lbu", got, 32'h000000AB);

        txn(1'b1, 3'b001, BASE + 32'h6, 32'h00008001, 0, got);
        txn(1'b0, 3'b001, BASE + 32'h6, 32'd0, 0, got);
        chk("t2_lh", got, 32'hFFFF8001);
        txn(1'b0, 3'b101, BASE + 32'h6, 32'd0, 0, got);
        chk("t2_lhu", got, 32'h00008001);
        txn(1'b0, 3'b010, BASE + 32'h4, 32'd0, 0, got);
        chk("t2_lw", got, 32'h8001AB44);

        // Faults: misaligned, illegal funct3, out of range
        txn(1'b0, 3'b010, BASE + 32'h2, 32'd0, 0, got);
        txn(1'b1, 3'b001, BASE + 32'h3, 32'h0000FFFF, 0, got);
        txn(1'b0, 3'b010, BASE + 32'h0, 32'd0, 0, got);
        txn(1'b1, 3'b011, BASE + 32'h8, 32'hDEADBEEF, 0, got);
        txn(1'b0, 3'b110, BASE + 32'h8, 32'd0, 0, got);
        txn(1'b0, 3'b010, BASE + 32'h8, 32'd0, 0, got);
        txn(1'b0, 3'b010, BASE + 32'(4*DEPTH), 32'd0, 0, got);
        txn(1'b0, 3'b010, BASE - 32'd4, 32'd0, 0, got);
        txn(1'b1, 3'b010, BASE + 32'(4*DEPTH), 32'h12345678, 0, got);
        txn(1'b0, 3'b010, BASE + 32'(4*DEPTH) - 32'd4, 32'd0, 0, got);

        // Long backpressure with stable response
        txn(1'b0, 3'b010, BASE + 32'h4, 32'd0, 5, got);

        // Reset while a store waits for its response
        a = BASE + 32'h20;
        model(1'b1, 3'b010, a, 32'hCAFEF00D, ed, ee);
        iReq_Valid = 1'b1; iReq_WrEn = 1'b1; iReq_Funct3 = 3'b010;
        iReq_Addr = a; iReq_WrData = 32'hCAFEF00D;
        @(posedge iClk); #1;
        iReq_Valid = 1'b0;
        iRst = 1'b1;
        #1;
        chk("t6_ready_in_reset", 32'(oReq_Ready), 32'd0);
        @(posedge iClk); #1;
        chk("t6_valid_after_reset", 32'(oRsp_Valid), 32'd0);
        chk("t6_ready_after_reset", 32'(oReq_Ready), 32'd0);
        iRst = 1'b0;
        #1;
        chk("t6_ready_released", 32'(oReq_Ready), 32'd1);
        @(posedge iClk); #1;
        txn(1'b0, 3'b010, a, 32'd0, 0, got);
        chk("t6_lw", got, 32'hCAFEF00D);

        // Random traffic, mostly legal, some faulting
        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      a = BASE + ($urandom % (4*DEPTH));
            else if (sel == 7) a = BASE - 32'd1 - ($urandom % 16);
            else if (sel == 8) a = BASE + 32'(4*DEPTH) + ($urandom % 16);
            else               a = $urandom;
            f = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) | (($urandom % 2 == 0) ? 3'b000 : 3'b100)
                                              : 3'($urandom);
            txn(1'($urandom), f, a, $urandom, int'($urandom_range(0, 2)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
